// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq execute stage: FSM states, op codes,
// flag bit positions and the flag-packing helper.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Control-unit / regfile side bus of the execute stage: request, operands,
// status and the result returned with its write strobe.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             wen_out;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, op, a, b,
    input  busy, done, wen_out, result, flags
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, wen_out, result, flags
  );
endinterface

// File: rtl/alu_mul16.sv
// Iterative unsigned shift-add multiplier: load captures operands, each step
// adds one partial product; last flags the final step, whose sum is prod_next.
module alu_mul16 #(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [4:0]         cnt_r;

  // The step's sum is exported so the caller can register the product on
  // the same edge that performs the final step.
  assign prod_next = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
  assign last      = step && (cnt_r == 5'(MUL_STEPS - 1));

  // Operand shift registers, accumulator and iteration counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= 5'd0;
    end else if (load) begin
      acc_r    <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      cnt_r    <= 5'd0;
    end else if (step) begin
      acc_r    <= prod_next;
      mcand_r  <= mcand_r << 1'b1;
      mplier_r <= mplier_r >> 1'b1;
      cnt_r    <= cnt_r + 5'd1;
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execute stage behind the register file: single-cycle logic/arith/shift ops,
// iterative multiply, start/busy/done handshake, result with write strobe.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  state_e             state_r;
  state_e             next_state_s;
  logic               mul_load_s;
  logic               mul_step_s;
  logic               mul_last_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_c_s;
  logic               alu_v_s;
  logic [3:0]         alu_flags_s;
  logic [WIDTH-1:0]   result_nxt_s;
  logic [3:0]         flags_nxt_s;
  logic [WIDTH-1:0]   result_r;
  logic [3:0]         flags_r;
  logic               busy_r;
  logic               done_r;
  logic [3:0]         sh_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH:0]     shl_ext_s;
  logic [WIDTH:0]     shr_ext_s;

  // One guard bit on each shift catches the last bit shifted out; with a zero
  // shift amount the guard stays 0, giving C=0 for free.
  assign sh_s      = bus.b[3:0];
  assign sum_s     = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_s    = {1'b0, bus.a} - {1'b0, bus.b};
  assign shl_ext_s = {1'b0, bus.a} << sh_s;
  assign shr_ext_s = {bus.a, 1'b0} >> sh_s;

  alu_mul16 #(
    .WIDTH     (WIDTH),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load_s),
    .step      (mul_step_s),
    .a         (bus.a),
    .b         (bus.b),
    .last      (mul_last_s),
    .prod_next (mul_prod_s)
  );

  // Single-cycle datapath and its flags, from the operands on the bus.
  always_comb begin
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res_s = bus.a & bus.b;
      OP_OR:  alu_res_s = bus.a | bus.b;
      OP_XOR: alu_res_s = bus.a ^ bus.b;
      OP_NOT: alu_res_s = ~bus.a;
      OP_SHL: begin
        alu_res_s = shl_ext_s[WIDTH-1:0];
        alu_c_s   = shl_ext_s[WIDTH];
      end
      OP_SHR: begin
        alu_res_s = shr_ext_s[WIDTH:1];
        alu_c_s   = shr_ext_s[0];
      end
      default: alu_res_s = '0;
    endcase
    alu_flags_s = pack_flags(alu_res_s == '0, alu_res_s[WIDTH-1], alu_c_s, alu_v_s);
  end

  // Next-state logic; result/flags only change on a completing edge.
  always_comb begin
    next_state_s = state_r;
    mul_load_s   = 1'b0;
    mul_step_s   = 1'b0;
    result_nxt_s = result_r;
    flags_nxt_s  = flags_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            mul_load_s   = 1'b1;
            next_state_s = ST_MUL;
          end else begin
            result_nxt_s = alu_res_s;
            flags_nxt_s  = alu_flags_s;
            next_state_s = ST_DONE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        mul_step_s = 1'b1;
        if (mul_last_s) begin
          result_nxt_s = mul_prod_s[WIDTH-1:0];
          flags_nxt_s  = pack_flags(mul_prod_s[WIDTH-1:0] == '0,
                                    mul_prod_s[WIDTH-1],
                                    |mul_prod_s[2*WIDTH-1:WIDTH],
                                    1'b0);
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_MUL;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered status and result, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      flags_r  <= 4'b0000;
    end else begin
      busy_r   <= (next_state_s == ST_MUL);
      done_r   <= (next_state_s == ST_DONE);
      result_r <= result_nxt_s;
      flags_r  <= flags_nxt_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.wen_out = done_r;
  assign bus.result  = result_r;
  assign bus.flags   = flags_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected {result,flags},
// a negedge monitor pops and compares on every done pulse.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_exp;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) bus();

  alu_seq #(.WIDTH(16), .MUL_STEPS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      check("wen_out", {31'd0, bus.wen_out}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_done", exp_q.size(), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {16'd0, bus.result}, {16'd0, mon_exp[19:4]});
        check("flags", {28'd0, bus.flags}, {28'd0, mon_exp[3:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [3:0] ef, input bit expect_done);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (expect_done) exp_q.push_back({er, ef});
  endtask

  task automatic single(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef);
    @(negedge clk);
    issue(op, a, b, er, ef, 1'b1);
    tick();
    bus.start = 1'b0;
    check({name, "_done"}, {31'd0, bus.done}, 32'd1);
    tick();
    check({name, "_done_low"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.a     = 16'd0;
    bus.b     = 16'd0;
    rst       = 1'b0;
    #3;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_wen", {31'd0, bus.wen_out}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_flags", {28'd0, bus.flags}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    single("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    single("sub_borrow", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110);
    single("sub_zero", OP_SUB, 16'h1234, 16'h1234, 16'h0000, 4'b1000);
    single("shr1", OP_SHR, 16'h8001, 16'h0001, 16'h4000, 4'b0010);
    single("shl0", OP_SHL, 16'h8001, 16'h0000, 16'h8001, 4'b0100);
    single("shl1", OP_SHL, 16'h8001, 16'h0001, 16'h0002, 4'b0010);
    single("not", OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 4'b0100);
    single("or", OP_OR, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000);
    single("reserved", 4'd9, 16'h1234, 16'h5678, 16'h0000, 4'b1000);

    // Multiply: 16 busy cycles, done in the 17th, mid-run start ignored.
    @(negedge clk);
    issue(OP_MUL, 16'h0100, 16'h0101, 16'h0100, 4'b0010, 1'b1);
    tick();
    bus.start = 1'b0;
    check("mul_busy_1", {31'd0, bus.busy}, 32'd1);
    check("mul_nodone_1", {31'd0, bus.done}, 32'd0);
    for (int i = 2; i <= 16; i++) begin
      tick();
      if (i == 5) issue(OP_ADD, 16'h0001, 16'h0001, 16'h0000, 4'b0000, 1'b0);
      if (i == 6) bus.start = 1'b0;
      check("mul_busy", {31'd0, bus.busy}, 32'd1);
      check("mul_nodone", {31'd0, bus.done}, 32'd0);
    end
    tick();
    check("mul_done", {31'd0, bus.done}, 32'd1);
    check("mul_busy_end", {31'd0, bus.busy}, 32'd0);
    tick();
    check("mul_done_low", {31'd0, bus.done}, 32'd0);

    // Asynchronous reset during multiply iteration 8.
    @(negedge clk);
    issue(OP_MUL, 16'h0100, 16'h0101, 16'h0000, 4'b0000, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_result", {16'd0, bus.result}, 32'd0);
    check("arst_flags", {28'd0, bus.flags}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    single("add_zero", OP_ADD, 16'h0000, 16'h0000, 16'h0000, 4'b1000);

    // Back-to-back: start held through the DONE cycle.
    @(negedge clk);
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b1);
    tick();
    issue(OP_XOR, 16'hFFFF, 16'h00FF, 16'hFF00, 4'b0100, 1'b1);
    check("b2b_done_1", {31'd0, bus.done}, 32'd1);
    tick();
    bus.start = 1'b0;
    check("b2b_done_2", {31'd0, bus.done}, 32'd1);
    tick();
    check("b2b_done_low", {31'd0, bus.done}, 32'd0);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
